// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ALU.
//   - opcode encodings (0x0-0x7 match the original 3-bit ALU with op[3]=0)
//   - FSM state type for the top-level sequencer
//   - bit positions inside the 5-bit flags vector {illegal, ovf, neg, carry, zero}
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SRL  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_EQL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  localparam int unsigned FLG_ZERO    = 0;
  localparam int unsigned FLG_CARRY   = 1;
  localparam int unsigned FLG_NEG     = 2;
  localparam int unsigned FLG_OVF     = 3;
  localparam int unsigned FLG_ILLEGAL = 4;
  localparam int unsigned NUM_FLAGS   = 5;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: radix-2 shift-add multiplier, one partial product per cycle.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   start          : load operands and begin (WIDTH iterations follow)
//   a, b           : unsigned operands
//   done           : product valid; holds until the next start
//   product        : full 2*WIDTH-bit product
// Only built into alu_pipe when ALU_MUL_EN is defined.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               armed_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
      armed_q  <= 1'b1;
    end else if (cnt_q != '0) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign done    = armed_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshakes and status flags.
//   clk_i, reset_i           : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  : operand handshake (a_i, b_i, op_i)
//   out_valid_o / out_ready_i: result handshake (alu_o, flags_o)
//   flags_o                  : {illegal, ovf, neg, carry, zero}
// Optional feature macro ALU_MUL_EN: enables the iterative multiplier for OP_MUL
// (latency WIDTH+1). Without it OP_MUL decodes as illegal.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [3:0]           op_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     alu_o,
  output logic [NUM_FLAGS-1:0] flags_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic                 can_load, accept, load;
  logic [WIDTH:0]       sum, diff;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res, res_d;
  logic                 alu_carry, alu_ovf, alu_ill;
  logic                 carry_d, ovf_d, ill_d;
  logic [NUM_FLAGS-1:0] flg_d;

  assign shamt = b_i[SHW-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLL:  alu_res = a_i << shamt;
      OP_SRL:  alu_res = a_i >> shamt;
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_EQL:  alu_res = {{(WIDTH-1){1'b0}}, a_i == b_i};
      OP_SRA:  alu_res = $signed(a_i) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
      // OP_MUL lands here too: illegal without the multiplier, and never
      // loaded from this path when the multiplier is present.
      default: alu_ill = 1'b1;
    endcase
  end

  assign can_load   = !out_valid_o || out_ready_i;
  assign in_ready_o = (state_q == ST_IDLE) && can_load;
  assign accept     = in_valid_i && in_ready_o;

`ifdef ALU_MUL_EN
  logic                 mul_start, mul_done, load_mul;
  logic [2*WIDTH-1:0]   mul_product;

  assign mul_start = accept && (op_i == OP_MUL);
  // A finished product waits in ST_MUL until the output register is free.
  assign load_mul  = (state_q == ST_MUL) && mul_done && can_load;
  assign load      = (accept && (op_i != OP_MUL)) || load_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start   (mul_start),
    .a       (a_i),
    .b       (b_i),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (load_mul)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`else
  assign load = accept;

  always_comb begin
    state_d = ST_IDLE;
  end
`endif

  always_comb begin
    res_d   = alu_res;
    carry_d = alu_carry;
    ovf_d   = alu_ovf;
    ill_d   = alu_ill;
`ifdef ALU_MUL_EN
    if (state_q == ST_MUL) begin
      res_d   = mul_product[WIDTH-1:0];
      carry_d = |mul_product[2*WIDTH-1:WIDTH];
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
    end
`endif
    flg_d              = '0;
    flg_d[FLG_ZERO]    = (res_d == '0);
    flg_d[FLG_CARRY]   = carry_d;
    flg_d[FLG_NEG]     = res_d[WIDTH-1];
    flg_d[FLG_OVF]     = ovf_d;
    flg_d[FLG_ILLEGAL] = ill_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      out_valid_o <= 1'b0;
      alu_o       <= '0;
      flags_o     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid_o <= 1'b1;
        alu_o       <= res_d;
        flags_o     <= flg_d;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe at WIDTH=8.
// Directed vector table, handshake/reset sequences, and a randomized phase
// checked against an integer-arithmetic reference model with a result queue.
module tb_alu_pipe;

  localparam int unsigned W = 8;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, alu;
  logic [3:0]   op;
  logic [4:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_o       (alu),
    .flags_o     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference model: {illegal, ovf, neg, carry, zero, result[7:0]}
  function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua = x;
    int ub = y;
    int sa = $signed(x);
    int sb = $signed(y);
    int sh = ub % 8;
    int r  = 0;
    int s  = 0;
    bit c = 0, v = 0, il = 0;
    logic [7:0] r8;
    case (o)
      4'h0: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      4'h1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      4'h2: r = ua * (1 << sh);
      4'h3: r = ua / (1 << sh);
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = ua ^ ub;
      4'h7: r = (ua == ub) ? 1 : 0;
      4'h8: r = sa >>> sh;
      4'h9: r = (sa < sb) ? 1 : 0;
      4'hA: r = (ua < ub) ? 1 : 0;
`ifdef ALU_MUL_EN
      4'hB: begin r = ua * ub; c = (r > 255); end
`endif
      default: il = 1;
    endcase
    r8 = r[7:0];
    return {il, v, r8[7], c, (r8 == 8'h00), r8};
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] flg;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] r, input logic [4:0] f);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.flg = f;
    vecs.push_back(v);
  endtask

  // Issue one operation (out_ready held 1) and wait for its result.
  // Entered and left at posedge+#1. Returns edges from accept to out_valid.
  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input string nm, output int lat, output int busy_rdy,
                        output logic [7:0] r, output logic [4:0] f);
    int cyc = 0;
    busy_rdy = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({nm, "_accept_wait"}, (cyc < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 4 * W) begin
      if (in_ready) busy_rdy++;
      @(posedge clk); #1; cyc++;
    end
    lat = cyc;
    r = alu;
    f = flags;
  endtask

  logic [12:0] sb[$];

  initial begin
    int lat, busy_rdy, exp_lat, held, seen;
    logic [7:0] r, pr;
    logic [4:0] f, pf;
    logic [12:0] m;

    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu", alu, 0);
    check("rst_flags", flags, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ---------------- directed table ----------------
    add_vec(4'h0, 8'hFF, 8'h01, 8'h00, 5'b00011);
    add_vec(4'h1, 8'h80, 8'h01, 8'h7F, 5'b01000);
    add_vec(4'h1, 8'h01, 8'h02, 8'hFF, 5'b00110);
    add_vec(4'h8, 8'h90, 8'h02, 8'hE4, 5'b00100);
    add_vec(4'h8, 8'h7F, 8'h03, 8'h0F, 5'b00000);
    add_vec(4'h2, 8'h01, 8'h0B, 8'h08, 5'b00000);
    add_vec(4'h9, 8'hFF, 8'h01, 8'h01, 5'b00000);
    add_vec(4'hA, 8'hFF, 8'h01, 8'h00, 5'b00001);
    add_vec(4'h7, 8'h5A, 8'h5A, 8'h01, 5'b00000);
    add_vec(4'h6, 8'h5A, 8'h5A, 8'h00, 5'b00001);
    add_vec(4'h4, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    add_vec(4'h5, 8'hF0, 8'h3C, 8'hFC, 5'b00100);
    add_vec(4'h3, 8'h80, 8'h07, 8'h01, 5'b00000);
    add_vec(4'h0, 8'h7F, 8'h01, 8'h80, 5'b01100);
    add_vec(4'h1, 8'h05, 8'h05, 8'h00, 5'b00001);
    add_vec(4'hD, 8'h12, 8'h34, 8'h00, 5'b10001);
    add_vec(4'hF, 8'hAA, 8'h55, 8'h00, 5'b10001);
`ifdef ALU_MUL_EN
    add_vec(4'hB, 8'h0F, 8'h11, 8'hFF, 5'b00100);
    add_vec(4'hB, 8'hFF, 8'hFF, 8'h01, 5'b00010);
`else
    add_vec(4'hB, 8'h0F, 8'h11, 8'h00, 5'b10001);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), lat, busy_rdy, r, f);
      exp_lat = 0;
`ifdef ALU_MUL_EN
      if (vecs[i].op == 4'hB) exp_lat = W + 1;
`endif
      check($sformatf("vec%0d_op%0h_res", i, vecs[i].op), r, vecs[i].res);
      check($sformatf("vec%0d_op%0h_flags", i, vecs[i].op), f, vecs[i].flg);
      check($sformatf("vec%0d_op%0h_latency", i, vecs[i].op), lat, exp_lat);
      check($sformatf("vec%0d_op%0h_busy_in_ready", i, vecs[i].op), busy_rdy, 0);
    end

    // ---------------- backpressure ----------------
    run_op(4'h0, 8'h03, 8'h04, "bp_first", lat, busy_rdy, r, f);
    check("bp_first_res", r, 8'h07);
    out_ready = 1'b0;
    op = 4'h1; a = 8'h09; b = 8'h03; in_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready_low%0d", k), in_ready, 0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      check($sformatf("bp_hold_alu%0d", k), alu, 8'h07);
      check($sformatf("bp_hold_flags%0d", k), flags, 5'b00000);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_alu", alu, 8'h06);
    @(posedge clk); #1;
    check("bp_no_duplicate", out_valid, 0);

    // ---------------- reset with a pending result ----------------
    run_op(4'h0, 8'h01, 8'h01, "rst_pend", lat, busy_rdy, r, f);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_pend_valid_before", out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_pend_valid_cleared", out_valid, 0);
    check("rst_pend_alu_cleared", alu, 0);
    #2 reset = 1'b0;
    #1;
    check("rst_pend_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    // ---------------- reset mid-multiply ----------------
    op = 4'hB; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    #1;
    check("mulrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mulrst_busy", in_ready, 0);
    reset = 1'b1;
    #1;
    check("mulrst_valid_low", out_valid, 0);
    #2 reset = 1'b0;
    #1;
    check("mulrst_in_ready_after", in_ready, 1);
    seen = 0;
    for (int k = 0; k < int'(W) + 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mulrst_no_result", seen, 0);
`endif

    // ---------------- randomized against reference model ----------------
    held = 0; pr = '0; pf = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (held != 0) begin
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_alu", alu, pr);
        check("rnd_hold_flags", flags, pf);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", out_valid, 0);
        end else begin
          m = sb.pop_front();
          check("rnd_res", alu, m[7:0]);
          check("rnd_flags", flags, m[12:8]);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op, a, b));
      held = (out_valid && !out_ready) ? 1 : 0;
      pr = alu;
      pf = flags;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4 * int'(W); c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("drain_spurious", out_valid, 0);
        end else begin
          m = sb.pop_front();
          check("drain_res", alu, m[7:0]);
          check("drain_flags", flags, m[12:8]);
        end
      end
    end
    check("drain_queue_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
